usb_phy_line: RTL and testbench
===============================

# usb_phy_line

Parametrised, vendor-neutral USB full-speed line PHY: the successor to the per-family tristate PHYs. It provides:
- Registered transmit drive with a tristate pad.
- Multi-stage receive synchronisation and a glitch-filtered line-state decoder.
- A transmit/turnaround state machine that masks self-echo.
- Bus-reset detection and, optionally, suspend detection.

It sits between the package pins and the USB serial interface engine, running on the 48 MHz core clock.

## Interface
- SYNC_STAGES, 2, receive synchroniser depth (≥2)
- FILTER_LEN, 2, consecutive identical samples required before line_state changes (≥1; 1 = no filtering)
- TURNAROUND, 4, cycles after usb_tx_en falls during which receive stays forced to J (≥1)
- RESET_CYCLES, 120, filtered-SE0 cycles before bus_reset asserts (2.5 µs @ 48 MHz)
- SUSPEND_CYCLES, 144000, filtered-J idle cycles before suspend asserts (3 ms @ 48 MHz)

Ports:
- clk_48mhz  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- pin_usb_p  inout  1  D+ pad
- pin_usb_n  inout  1  D- pad
- usb_p_tx  in  1  D+ transmit level
- usb_n_tx  in  1  D- transmit level
- usb_tx_en  in  1  transmit request; pads driven while high
- usb_p_rx  out  1  synchronised D+, forced 1 while masked
- usb_n_rx  out  1  synchronised D-, forced 0 while masked
- line_state  out  2  filtered {D+,D-}: SE0=00, K=01, J=10, SE1=11
- bus_reset  out  1  SE0 held ≥ RESET_CYCLES
- suspend  out  1  J idle ≥ SUSPEND_CYCLES
- tx_busy  out  1  high in TX or TURN

## Operation
- Transmit path:
  - usb_p_tx, usb_n_tx and usb_tx_en are registered once.
  - The pad output enable is the registered usb_tx_en.
  - The pad drives the registered levels.
- Receive path:
  - Each pad input passes through SYNC_STAGES flops.
  - usb_p_rx and usb_n_rx come from the last stage, overridden to J (1, 0) when masked.
- State machine (RX, TX, TURN); reset state is RX.
  - RX → TX on usb_tx_en=1.
  - TX → TURN on usb_tx_en=0; the turnaround counter loads TURNAROUND-1.
  - TURN decrements each cycle → RX when the count reaches 0.
  - TURN → TX if usb_tx_en=1; this takes priority over count expiry and clears the counter.
  - Masked means state ≠ RX.
- Filter:
  - A candidate register holds the last synchronised {p,n}.
  - A stability counter increments while the sample equals the candidate and reloads to 1 on any change.
  - line_state updates when the count reaches FILTER_LEN; the counter saturates there.
  - When masked, the filter input is forced to J.
- Bus reset:
  - The SE0 counter increments while line_state=SE0 and is not masked, saturating at RESET_CYCLES.
  - It clears otherwise.
  - bus_reset = (count == RESET_CYCLES), registered. It stays high until line_state leaves SE0.
- Suspend:
  - Same scheme as bus reset, with line_state=J and SUSPEND_CYCLES.
  - The counter clears on any non-J state and while in TX.
  - TURN does not clear the counter, because a forced J during TURN is genuine idle.
- Counter widths are $clog2(limit+1). No wrap is permitted; all counters saturate.

## Timing
- Reset values:
  - Pads tristated.
  - usb_p_rx=1, usb_n_rx=0.
  - line_state=10.
  - bus_reset=0, suspend=0, tx_busy=0.
  - All counters 0; state RX.
- Asynchronous reset assertion mid-transmit releases the pads immediately, without waiting for a clock edge.
- Transmit latency: pin to input change is 1 cycle. tx_busy rises 1 cycle after usb_tx_en rises.
- Receive latency:
  - pin to usb_p_rx/usb_n_rx: SYNC_STAGES cycles.
  - pin to line_state: SYNC_STAGES+FILTER_LEN cycles.
- The mask releases TURNAROUND cycles after the registered enable falls.
- bus_reset rises RESET_CYCLES+1 cycles after line_state first shows SE0.
- SE0 seen during TX or TURN never counts toward bus_reset.

## Configuration
- USB_PHY_SUSPEND_DET_EN defined: the suspend counter and comparator are built.
- Undefined: the logic is removed, and suspend is tied to 0.

## Structure
- Shared package usb_phy_pkg contains:
  - Line-state constants LS_SE0, LS_K, LS_J, LS_SE1.
  - The state encoding ST_RX, ST_TX, ST_TURN.
- Sub-module usb_phy_line_filter contains the candidate register, stability counter and line_state register, parametrised by FILTER_LEN.
- Pad tristate is inferred (assign pin = oe ? lvl : 1'bz). No vendor primitives are used.

## Test plan
- Reset released with pins pulled to J → line_state=10, bus_reset=0, pads Z, usb_p_rx=1, usb_n_rx=0.
- Drive SE0 on pins for 125 cycles (defaults) → bus_reset rises at cycle 2+2+121 after SE0 applied; falls 4 cycles after J restored.
- Pin glitch to K for 1 cycle with FILTER_LEN=2 → line_state stays 10; K held 2 cycles → line_state=01 after 4 cycles.
- usb_tx_en high 10 cycles driving K/J/SE0 → pads follow with 1-cycle lag, usb_p_rx/usb_n_rx held 1/0, no bus_reset; mask lifts 4 cycles after the registered enable falls.
- usb_tx_en re-asserted in TURN cycle 2 → state returns to TX, tx_busy never drops.
- With USB_PHY_SUSPEND_DET_EN and SUSPEND_CYCLES=50: J idle 60 cycles → suspend=1; K for FILTER_LEN cycles → suspend=0. Without the macro, suspend stays 0.

Source files
------------

// File: rtl/usb_phy_pkg.sv
// Shared definitions for the USB full-speed line PHY: line-state codes and the
// transmit/turnaround state encoding.
package usb_phy_pkg;

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [1:0] {
    ST_RX   = 2'd0,
    ST_TX   = 2'd1,
    ST_TURN = 2'd2
  } phy_state_e;

endpackage

// File: rtl/usb_phy_line_filter.sv
// Glitch filter for the synchronised {D+,D-} pair: line_state only moves once the
// same sample has been seen FILTER_LEN times in a row.
module usb_phy_line_filter
  import usb_phy_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 2
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  input  logic [1:0] sample,
  output logic [1:0] line_state
);

  localparam int unsigned     CntW   = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN);

  logic [1:0]      cand_q;
  logic [1:0]      ls_q, ls_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (sample != cand_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    // The counter saturates at CntMax, so a stable input keeps reloading the same value.
    ls_d = (cnt_d == CntMax) ? sample : ls_q;
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      cand_q <= LS_J;
      cnt_q  <= '0;
      ls_q   <= LS_J;
    end else begin
      cand_q <= sample;
      cnt_q  <= cnt_d;
      ls_q   <= ls_d;
    end
  end

  assign line_state = ls_q;

endmodule

// File: rtl/usb_phy_line.sv
// Vendor-neutral USB full-speed line PHY: registered tristate drive, receive sync and
// filtering, self-echo masking, bus-reset detect. Suspend detect with USB_PHY_SUSPEND_DET_EN.
module usb_phy_line
  import usb_phy_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_LEN     = 2,
  parameter int unsigned TURNAROUND     = 4,
  parameter int unsigned RESET_CYCLES   = 120,
  parameter int unsigned SUSPEND_CYCLES = 144000
) (
  input  logic       clk_48mhz,
  input  logic       reset_n,
  inout  wire        pin_usb_p,
  inout  wire        pin_usb_n,
  input  logic       usb_p_tx,
  input  logic       usb_n_tx,
  input  logic       usb_tx_en,
  output logic       usb_p_rx,
  output logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       bus_reset,
  output logic       suspend,
  output logic       tx_busy
);

  localparam int unsigned     TurnW  = $clog2(TURNAROUND + 1);
  localparam int unsigned     RstW   = $clog2(RESET_CYCLES + 1);
  localparam logic [RstW-1:0] RstMax = RstW'(RESET_CYCLES);

  // Transmit path; the async reset clears oe_q, so the pads release without a clock.
  logic p_tx_q, n_tx_q, oe_q;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      p_tx_q <= 1'b0;
      n_tx_q <= 1'b0;
      oe_q   <= 1'b0;
    end else begin
      p_tx_q <= usb_p_tx;
      n_tx_q <= usb_n_tx;
      oe_q   <= usb_tx_en;
    end
  end

  assign pin_usb_p = oe_q ? p_tx_q : 1'bz;
  assign pin_usb_n = oe_q ? n_tx_q : 1'bz;

  // Receive synchronisers, reset to J so the idle line is seen from the first cycle.
  logic [SYNC_STAGES-1:0] sync_p_q, sync_n_q;

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_p_q <= '1;
      sync_n_q <= '0;
    end else begin
      sync_p_q <= {sync_p_q[SYNC_STAGES-2:0], pin_usb_p};
      sync_n_q <= {sync_n_q[SYNC_STAGES-2:0], pin_usb_n};
    end
  end

  // Transmit/turnaround FSM.
  phy_state_e       state_q, state_d;
  logic [TurnW-1:0] turn_cnt_q, turn_cnt_d;
  logic             masked;

  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    unique case (state_q)
      ST_RX: begin
        if (usb_tx_en) state_d = ST_TX;
      end
      ST_TX: begin
        if (!usb_tx_en) begin
          state_d    = ST_TURN;
          turn_cnt_d = TurnW'(TURNAROUND - 1);
        end
      end
      ST_TURN: begin
        if (usb_tx_en) begin
          state_d    = ST_TX;
          turn_cnt_d = '0;
        end else if (turn_cnt_q == '0) begin
          state_d = ST_RX;
        end else begin
          turn_cnt_d = turn_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RX;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  assign masked   = (state_q != ST_RX);
  assign tx_busy  = masked;
  assign usb_p_rx = masked | sync_p_q[SYNC_STAGES-1];
  assign usb_n_rx = ~masked & sync_n_q[SYNC_STAGES-1];

  usb_phy_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk_48mhz  (clk_48mhz),
    .reset_n    (reset_n),
    .sample     ({usb_p_rx, usb_n_rx}),
    .line_state (line_state)
  );

  // Bus reset: saturating count of unmasked SE0 cycles.
  logic [RstW-1:0] se0_cnt_q, se0_cnt_d;
  logic            bus_reset_q;

  always_comb begin
    se0_cnt_d = '0;
    if ((line_state == LS_SE0) && !masked) begin
      se0_cnt_d = (se0_cnt_q == RstMax) ? se0_cnt_q : se0_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end else begin
      se0_cnt_q   <= se0_cnt_d;
      bus_reset_q <= (se0_cnt_q == RstMax);
    end
  end

  // The registered flag drops in the same cycle the filtered line leaves SE0.
  assign bus_reset = bus_reset_q & (line_state == LS_SE0);

`ifdef USB_PHY_SUSPEND_DET_EN
  localparam int unsigned     SusW   = $clog2(SUSPEND_CYCLES + 1);
  localparam logic [SusW-1:0] SusMax = SusW'(SUSPEND_CYCLES);

  logic [SusW-1:0] idle_cnt_q, idle_cnt_d;
  logic            suspend_q;

  // TURN keeps counting: the forced J there is a genuinely idle bus.
  always_comb begin
    idle_cnt_d = '0;
    if ((line_state == LS_J) && (state_q != ST_TX)) begin
      idle_cnt_d = (idle_cnt_q == SusMax) ? idle_cnt_q : idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_48mhz or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
      suspend_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      suspend_q  <= (idle_cnt_q == SusMax);
    end
  end

  assign suspend = suspend_q & (line_state == LS_J);
`else
  logic [31:0] unused_suspend_cycles;
  assign unused_suspend_cycles = SUSPEND_CYCLES;
  assign suspend               = 1'b0;
`endif

endmodule

// File: tb/tb_usb_phy_line.sv
// Randomised bench for usb_phy_line against a cycle-history reference model built from
// the line, masking and counting rules (window checks over recorded pin/enable history).
module tb_usb_phy_line;
  import usb_phy_pkg::*;

  localparam int S    = 2;
  localparam int L    = 2;
  localparam int T    = 4;
  localparam int R    = 120;
  localparam int SC   = 50;
  localparam int MAXC = 8192;
`ifdef USB_PHY_SUSPEND_DET_EN
  localparam logic SUSP_EXP = 1'b1;
`else
  localparam logic SUSP_EXP = 1'b0;
`endif

  logic       clk_48mhz = 1'b0;
  logic       reset_n;
  logic       usb_p_tx, usb_n_tx, usb_tx_en;
  logic       usb_p_rx, usb_n_rx;
  logic [1:0] line_state;
  logic       bus_reset, suspend, tx_busy;
  wire        pin_usb_p, pin_usb_n;
  logic       tb_drv;
  logic [1:0] tb_pin;

  always #5 clk_48mhz = ~clk_48mhz;

  assign pin_usb_p = tb_drv ? tb_pin[1] : 1'bz;
  assign pin_usb_n = tb_drv ? tb_pin[0] : 1'bz;

  usb_phy_line #(
    .SYNC_STAGES    (S),
    .FILTER_LEN     (L),
    .TURNAROUND     (T),
    .RESET_CYCLES   (R),
    .SUSPEND_CYCLES (SC)
  ) dut (
    .clk_48mhz  (clk_48mhz),
    .reset_n    (reset_n),
    .pin_usb_p  (pin_usb_p),
    .pin_usb_n  (pin_usb_n),
    .usb_p_tx   (usb_p_tx),
    .usb_n_tx   (usb_n_tx),
    .usb_tx_en  (usb_tx_en),
    .usb_p_rx   (usb_p_rx),
    .usb_n_rx   (usb_n_rx),
    .line_state (line_state),
    .bus_reset  (bus_reset),
    .suspend    (suspend),
    .tx_busy    (tx_busy)
  );

  int checks   = 0;
  int failures = 0;
  int k;

  // History indexed by clock edge since reset (index 0 = reset state).
  logic       en_h [MAXC];
  logic [1:0] tx_h [MAXC];
  logic [1:0] in_h [MAXC];
  logic [1:0] ls_h [MAXC];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Masked after edge j if the enable was sampled high in any of the last T+1 edges.
  function automatic logic m_masked(input int j);
    for (int i = j - T; i <= j; i++) if (i >= 0 && en_h[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] m_rxraw(input int j);
    return (j - S + 1 >= 1) ? in_h[j-S+1] : LS_J;
  endfunction

  // Filter input seen at edge j.
  function automatic logic [1:0] m_f(input int j);
    return m_masked(j - 1) ? LS_J : m_rxraw(j - 1);
  endfunction

  function automatic logic m_bus(input int j);
    if (ls_h[j] != LS_SE0 || j - R - 1 < 0) return 1'b0;
    for (int i = j - R - 1; i <= j - 2; i++)
      if (ls_h[i] != LS_SE0 || m_masked(i)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_susp(input int j);
`ifdef USB_PHY_SUSPEND_DET_EN
    if (ls_h[j] != LS_J || j - SC - 1 < 0) return 1'b0;
    for (int i = j - SC - 1; i <= j - 2; i++)
      if (ls_h[i] != LS_J || en_h[i]) return 1'b0;
    return 1'b1;
`else
    return (j < 0);
`endif
  endfunction

  task automatic model_reset();
    k        = 0;
    en_h[0]  = 1'b0;
    tx_h[0]  = 2'b00;
    in_h[0]  = LS_J;
    ls_h[0]  = LS_J;
  endtask

  task automatic check_all();
    logic all_eq;
    if (k > 0) begin
      all_eq = (k >= L);
      for (int i = k - L + 1; i <= k; i++) if (i >= 1 && m_f(i) != m_f(k)) all_eq = 1'b0;
      ls_h[k] = all_eq ? m_f(k) : ls_h[k-1];
    end
    check_eq("line_state", line_state, ls_h[k]);
    check_eq("rx_pair", {usb_p_rx, usb_n_rx}, m_masked(k) ? LS_J : m_rxraw(k));
    check_eq("tx_busy", tx_busy, m_masked(k));
    check_eq("bus_reset", bus_reset, m_bus(k));
    check_eq("suspend", suspend, m_susp(k));
    if (en_h[k]) check_eq("pad_drive", {pin_usb_p, pin_usb_n}, tx_h[k]);
    else if (tb_drv) check_eq("pad_release", {pin_usb_p, pin_usb_n}, tb_pin);
  endtask

  // Called between edges; the bench only drives pins when the DUT cannot be driving.
  task automatic step(input logic en, input logic [1:0] txl, input logic [1:0] pin);
    logic drv;
    drv       = !en_h[k] && !en;
    usb_tx_en = en;
    {usb_p_tx, usb_n_tx} = txl;
    tb_drv    = drv;
    tb_pin    = pin;
    in_h[k+1] = drv ? pin : (en_h[k] ? tx_h[k] : LS_J);
    en_h[k+1] = en;
    tx_h[k+1] = txl;
    @(posedge clk_48mhz);
    k++;
    #1;
    check_all();
    @(negedge clk_48mhz);
  endtask

  task automatic hold(input logic [1:0] pin, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'($urandom), pin);
  endtask

  task automatic tx_burst(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'($urandom_range(0, 2)), LS_J);
  endtask

  task automatic reassert(input int n1, input int gap, input int n2, output int drops);
    drops = 0;
    for (int i = 0; i < n1 + gap + n2; i++) begin
      step((i < n1 || i >= n1 + gap), 2'($urandom_range(0, 2)), LS_J);
      if (!tx_busy) drops++;
    end
  endtask

  initial begin
    int rise, fall, saw, busy, drops;
    reset_n   = 1'b0;
    tb_drv    = 1'b1;
    tb_pin    = LS_J;
    usb_tx_en = 1'b0;
    usb_p_tx  = 1'b0;
    usb_n_tx  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_48mhz);
    reset_n = 1'b1;
    #1;
    check_all();

    hold(LS_J, 3);
    rise = 0;
    for (int i = 1; i <= 125; i++) begin
      step(1'b0, 2'($urandom), LS_SE0);
      if (bus_reset && rise == 0) rise = i;
    end
    check_eq("bus_reset_rise", rise, 125);
    fall = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 2'($urandom), LS_J);
      if (!bus_reset && fall == 0) fall = i;
    end
    check_eq("bus_reset_fall", fall, 4);

    hold(LS_J, 4);
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'($urandom), (i == 0) ? LS_K : LS_J);
      if (line_state != LS_J) saw = 1;
    end
    check_eq("glitch_filtered", saw, 0);
    hold(LS_K, 2);
    hold(LS_J, 2);
    check_eq("k_after_4", line_state, LS_K);
    hold(LS_J, 4);

    tx_burst(10);
    busy = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 2'($urandom), LS_J);
      if (tx_busy) busy++;
    end
    check_eq("mask_release", busy, 4);

    reassert(6, 2, 6, drops);
    check_eq("busy_through_reassert", drops, 0);
    hold(LS_J, 60);
    check_eq("suspend_idle", suspend, SUSP_EXP);
    hold(LS_K, 2);
    hold(LS_J, 4);
    check_eq("suspend_cleared", suspend, 0);

    // Reset asserted between edges while transmitting must free the pads at once.
    tx_burst(3);
    #2;
    reset_n   = 1'b0;
    usb_tx_en = 1'b0;
    tb_drv    = 1'b1;
    tb_pin    = LS_J;
    #1;
    check_eq("async_pad_release", {pin_usb_p, pin_usb_n}, LS_J);
    check_eq("async_busy", tx_busy, 0);
    check_eq("async_rx", {usb_p_rx, usb_n_rx}, LS_J);
    check_eq("async_line_state", line_state, LS_J);
    repeat (2) @(negedge clk_48mhz);
    reset_n = 1'b1;
    model_reset();
    #1;
    check_all();

    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 5))
        0: hold(LS_J, $urandom_range(1, 80));
        1: hold(LS_SE0, $urandom_range(100, 140));
        2: begin
          hold(LS_K, $urandom_range(1, 3));
          hold(LS_J, 4);
        end
        3: begin
          tx_burst($urandom_range(1, 12));
          hold(LS_J, $urandom_range(0, 6));
        end
        4: begin
          reassert($urandom_range(1, 8), $urandom_range(1, 3), $urandom_range(1, 8), drops);
          hold(LS_J, $urandom_range(0, 6));
        end
        default: begin
          for (int i = 0; i < $urandom_range(5, 30); i++)
            step(1'b0, 2'($urandom), 2'($urandom));
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
